// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the oversampling UART receiver.
//   DATA_W          : payload bits per frame
//   VOTE_S0..S2     : sample-counter values at which the line is captured for the majority vote
//   DEF_TICK_DIV    : default clk cycles per oversample tick (50 MHz / (9600*16))
//   DEF_OVERSAMPLE  : default oversample ticks per bit period
//   rx_state_t      : receiver FSM states
//   maj3            : 2-of-3 majority
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int VOTE_S0        = 7;
  localparam int VOTE_S1        = 8;
  localparam int VOTE_S2        = 9;
  localparam int DEF_TICK_DIV   = 326;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if -- receiver-to-control result bundle.
//   RX_DATA    : last good byte (LSB first on the line)
//   RX_STATUS  : one-clk pulse, RX_DATA just updated
//   RX_ERR     : one-clk pulse, framing error
//   RX_PERR    : one-clk pulse, parity mismatch
//   rx_busy    : frame in progress
// master = receiver (drives), slave = consumer (reads).
interface uart_rx_oversample_if;

  logic [uart_pkg::DATA_W-1:0] RX_DATA;
  logic                        RX_STATUS;
  logic                        RX_ERR;
  logic                        RX_PERR;
  logic                        rx_busy;

  modport master (
    output RX_DATA,
    output RX_STATUS,
    output RX_ERR,
    output RX_PERR,
    output rx_busy
  );

  modport slave (
    input RX_DATA,
    input RX_STATUS,
    input RX_ERR,
    input RX_PERR,
    input rx_busy
  );

endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen -- free-running divider producing a one-clk tick enable.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   tick  out high for the single clk where the counter sits at TICK_DIV-1
// Never realigned; shared by receiver and transmitter.
module uart_tick_gen #(
  parameter int TICK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]     LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample -- 16x-oversampling UART receiver on the system clock.
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   UART_RX in   raw serial line (asynchronous, idle high)
//   rx_if   master: RX_DATA, RX_STATUS, RX_ERR, RX_PERR, rx_busy
// Build option: define UART_RX_PARITY_EN for start+8+parity+stop frames with a live
// RX_PERR; otherwise frames are 8N1 and RX_PERR is tied low.
// Each bit is the majority of three mid-bit samples; a start bit that votes high is
// treated as a glitch. The FSM returns to IDLE at the middle of the stop bit so the
// next falling edge can be caught without slipping.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RX,
  uart_rx_oversample_if.master rx_if
);

  localparam int             SW     = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]  S_V0   = SW'(VOTE_S0);
  localparam logic [SW-1:0]  S_V1   = SW'(VOTE_S1);
  localparam logic [SW-1:0]  S_V2   = SW'(VOTE_S2);
  localparam logic [SW-1:0]  S_LAST = SW'(OVERSAMPLE - 1);
  localparam int             IW     = $clog2(DATA_W);
  localparam logic [IW-1:0]  I_LAST = IW'(DATA_W - 1);

  // Elaboration-time parameter sanity.
  if (OVERSAMPLE < 12) begin : g_bad_oversample
    $error("OVERSAMPLE must be >= 12");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  logic tick;

  uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; reset to the idle level so no false start follows reset.
  logic rx_meta_reg;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= UART_RX;
      rx_s        <= rx_meta_reg;
    end
  end

  rx_state_t         state_reg;
  logic [SW-1:0]     s_reg;
  logic [IW-1:0]     idx_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [DATA_W-1:0] data_reg;
  logic              v0_reg;
  logic              v1_reg;
  logic              armed_reg;
  logic              busy_reg;
  logic              status_reg;
  logic              err_reg;

  // The third sample is taken live at s=9, so the vote resolves on that tick.
  logic vote;
  assign vote = maj3(v0_reg, v1_reg, rx_s);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_POL = (PARITY_ODD != 0);
  logic par_bad_reg;
  logic perr_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      idx_reg     <= '0;
      shreg_reg   <= '0;
      data_reg    <= '0;
      v0_reg      <= 1'b1;
      v1_reg      <= 1'b1;
      armed_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      status_reg  <= 1'b0;
      err_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      status_reg <= 1'b0;
      err_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg   <= 1'b0;
`endif
      if (tick) begin
        s_reg <= (s_reg == S_LAST) ? '0 : s_reg + 1'b1;
        if (s_reg == S_V0) v0_reg <= rx_s;
        if (s_reg == S_V1) v1_reg <= rx_s;

        case (state_reg)
          IDLE: begin
            // Arming needs a high line first, so a held-low break cannot retrigger.
            if (rx_s) armed_reg <= 1'b1;
            if (armed_reg && !rx_s) begin
              state_reg   <= START;
              s_reg       <= '0;
              busy_reg    <= 1'b1;
              armed_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_bad_reg <= 1'b0;
`endif
            end
          end

          START: begin
            if (s_reg == S_V2 && vote) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (s_reg == S_LAST) begin
              state_reg <= DATA;
              idx_reg   <= '0;
            end
          end

          DATA: begin
            if (s_reg == S_V2) shreg_reg[idx_reg] <= vote;
            if (s_reg == S_LAST) begin
              if (idx_reg == I_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (s_reg == S_V2) par_bad_reg <= (vote != ((^shreg_reg) ^ PAR_POL));
            if (s_reg == S_LAST) state_reg <= STOP;
          end
`endif

          STOP: begin
            if (s_reg == S_V2) begin
              if (vote) begin
                data_reg   <= shreg_reg;
                status_reg <= 1'b1;
              end else begin
                err_reg <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              perr_reg  <= par_bad_reg;
`endif
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.RX_DATA   = data_reg;
  assign rx_if.RX_STATUS = status_reg;
  assign rx_if.RX_ERR    = err_reg;
  assign rx_if.rx_busy   = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign rx_if.RX_PERR   = perr_reg;
`else
  assign rx_if.RX_PERR   = 1'b0;
`endif

endmodule
